// File: rtl/operand_ctrl_pkg.sv
// operand_ctrl_pkg: shared state encoding and counter width for operand_load_ctrl
package operand_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, GET_B, START, WAIT, RESP} ctrl_state_t;
  localparam int OP_COUNT_W = 8;
endpackage

// File: rtl/operand_load_ctrl.sv
// operand_load_ctrl: steers A/B operand bytes, starts the ALU and holds the result; ALU_TIMEOUT_EN adds a WAIT watchdog
module operand_load_ctrl
  import operand_ctrl_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic [DATA_W-1:0]     data_out,
  output logic                  load_a,
  output logic                  load_b,
  output logic                  alu_start,
  input  logic                  alu_done,
  output logic                  busy,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  err,
  output logic [OP_COUNT_W-1:0] op_count
);
  ctrl_state_t r_state, w_next;
  logic [OP_COUNT_W-1:0] r_count;
  logic w_done, w_timeout;
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end
  // strobes are gated by rst so a handshake coinciding with reset never loads
  assign in_ready  = r_state == IDLE || r_state == GET_B;
  assign load_a    = r_state == IDLE && in_valid && !rst;
  assign load_b    = r_state == GET_B && in_valid && !rst;
  assign data_out  = in_data;
  assign alu_start = r_state == START;
  assign busy      = r_state != IDLE;
  assign res_valid = r_state == RESP;
  assign op_count  = r_count;
  assign w_done    = r_state == WAIT && alu_done;
`ifdef ALU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_tmo;
  logic r_err;
  // counter idles at zero outside WAIT, so it is cleared on every WAIT entry
  assign w_timeout = r_state == WAIT && !alu_done && r_tmo == CNT_W'(TIMEOUT_CYCLES - 1);
  assign err       = r_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      r_tmo <= r_state == WAIT ? r_tmo + 1'b1 : '0;
      r_err <= w_timeout ? 1'b1 : load_a ? 1'b0 : r_err;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = GET_B;
      GET_B:   if (in_valid) w_next = START;
      START:   w_next = WAIT;
      WAIT:    if (w_done || w_timeout) w_next = RESP;
      RESP:    if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_count <= w_done ? r_count + 1'b1 : r_count;
    end
  end
endmodule

// File: tb/tb_operand_load_ctrl.sv
// tb_operand_load_ctrl: randomized scoreboard bench for operand_load_ctrl
module tb_operand_load_ctrl;
  logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, alu_done = 1'b0, res_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, load_a, load_b, alu_start, busy, res_valid, err;
  logic [7:0] data_out, op_count;
  int errs = 0, checks = 0, model_cnt = 0;
  typedef struct {bit is_b; logic [7:0] d;} load_t;
  typedef struct {logic [7:0] cnt; bit e;} res_t;
  load_t lq[$];
  res_t  rq[$];
  load_t le;
  res_t  re;

  operand_load_ctrl #(.DATA_W(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .data_out(data_out), .load_a(load_a), .load_b(load_b), .alu_start(alu_start),
    .alu_done(alu_done), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .err(err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: pops expected loads/results whenever the DUT presents them
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("data_out", data_out, in_data);
      if (load_a && load_b) chk("load_exclusive", 2'b11, 2'b00);
      if (load_a || load_b) begin
        if (lq.size() == 0) chk("load_unexpected", {load_a, load_b}, 2'b00);
        else begin
          le = lq.pop_front();
          chk("load_sel_b", load_b, le.is_b);
          chk("load_data", data_out, le.d);
        end
      end
      if (res_valid && res_ready) begin
        if (rq.size() == 0) chk("res_unexpected", 1, 0);
        else begin
          re = rq.pop_front();
          chk("res_count", op_count, re.cnt);
          chk("res_err", err, re.e);
        end
      end
    end
  end

  // must be called right after tick(); returns right after the handshake edge
  task automatic send(bit is_b, logic [7:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    lq.push_back('{is_b, d});
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic run_op(logic [7:0] a, logic [7:0] b, int gap, int dly, int rdly, bit junk);
    send(0, a);
    chk("err_clear_on_a", err, 0);
    repeat (gap) tick();
    send(1, b);
    if (junk) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    chk("alu_start", alu_start, 1);
    chk("start_ready", in_ready, 0);
    if (junk && $urandom_range(0, 1) == 1) alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    repeat (dly) begin
      @(negedge clk);
      chk("wait_ready", in_ready, 0);
      chk("wait_start", alu_start, 0);
      chk("wait_res_valid", res_valid, 0);
      tick();
    end
    alu_done  = 1'b1;
    model_cnt = (model_cnt + 1) % 256;
    rq.push_back('{model_cnt[7:0], 1'b0});
    @(negedge clk);
    chk("done_res_valid", res_valid, 0);
    tick();
    alu_done = 1'b0;
    repeat (rdly) begin
      @(negedge clk);
      chk("resp_hold", res_valid, 1);
      tick();
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("resp_valid", res_valid, 1);
    chk("resp_ready", in_ready, 0);
    chk("op_count", op_count, model_cnt);
    tick();
    res_ready = 1'b0;
    in_valid  = 1'b0;
    chk("back_idle", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h77;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_vs_valid_load", load_a, 0);
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_start", alu_start, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_err", err, 0);
    chk("reset_op_count", op_count, 0);
    chk("reset_loads", {load_a, load_b}, 0);
    // mid-operation reset: pending result is discarded
    send(0, 8'h11);
    send(1, 8'h22);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    alu_done = 1'b1;
    model_cnt = 0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    tick();
    alu_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_res_valid", res_valid, 0);
      chk("midrst_op_count", op_count, model_cnt);
      tick();
    end
    // basic: done 4 cycles after start, immediate ack
    run_op(8'h3C, 8'hA5, 0, 3, 0, 0);
    // done coinciding with the would-be timeout cycle completes normally
    run_op(8'h5A, 8'hC3, 0, 15, 0, 1);
`ifdef ALU_TIMEOUT_EN
    send(0, 8'h01);
    send(1, 8'h02);
    tick();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("tmo_wait_res_valid", res_valid, 0);
      tick();
    end
    chk("tmo_res_valid", res_valid, 1);
    chk("tmo_err", err, 1);
    rq.push_back('{model_cnt[7:0], 1'b1});
    res_ready = 1'b1;
    @(negedge clk);
    tick();
    res_ready = 1'b0;
`endif
    for (int i = 0; i < 30; i++)
      run_op(8'($urandom), 8'($urandom), $urandom_range(0, 2), $urandom_range(0, 5),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    while (model_cnt != 255) run_op(8'($urandom), 8'($urandom), 0, 0, 0, 0);
    chk("pre_wrap_count", op_count, 255);
    run_op(8'hFF, 8'h00, 0, 1, 0, 1);
    chk("wrap_count", op_count, 0);
    repeat (2) tick();
    chk("load_queue_drained", lq.size(), 0);
    chk("res_queue_drained", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/operand_load_ctrl.md
# operand_load_ctrl

Sequencer for the 8-bit operand register pair (A and B) that feeds the ALU.
- Accepts operand bytes over a valid/ready stream.
- Steers each byte into the A or B operand register with a one-cycle load pulse.
- Starts the ALU, waits for completion, and holds a result-valid flag until the consumer acknowledges it.
- Sits between the byte input port and the operand registers/ALU, and is the only driver of their load strobes.

## Interface
Parameters:
- DATA_W, 8, width of the operand bytes and of data_out.
- TIMEOUT_CYCLES, 16, maximum number of WAIT cycles before a timeout error (used only with ALU_TIMEOUT_EN).

Ports:
- clk  in  1  single system clock; everything is updated on the rising edge.
- rst  in  1  synchronous, active-high reset; shares the operand registers' reset net.
- in_valid  in  1  operand byte present on in_data.
- in_data  in  DATA_W  operand byte.
- in_ready  out  1  controller can accept a byte this cycle.
- data_out  out  DATA_W  combinational copy of in_data; drives data_in of both operand registers.
- load_a  out  1  load strobe for operand register A.
- load_b  out  1  load strobe for operand register B.
- alu_start  out  1  one-cycle ALU start pulse.
- alu_done  in  1  ALU completion pulse.
- busy  out  1  high in every state except IDLE.
- res_valid  out  1  ALU result ready for the consumer.
- res_ready  in  1  consumer acknowledges the result.
- err  out  1  sticky timeout flag.
- op_count  out  8  number of completed operations; wraps modulo 256.

## Operation
- States: IDLE, GET_B, START, WAIT, RESP.
- IDLE:
  - in_ready=1.
  - On in_valid: load_a=1 combinationally in the same cycle, then go to GET_B.
  - err clears on this handshake.
- GET_B:
  - in_ready=1.
  - On in_valid: load_b=1 combinationally, then go to START.
- START: alu_start=1 for exactly one cycle, then go to WAIT unconditionally.
- WAIT:
  - On alu_done: op_count+1 (8'hFF wraps to 8'h00), then go to RESP.
  - Without the macro, WAIT waits indefinitely.
- RESP:
  - res_valid=1.
  - On res_ready: go to IDLE.
- alu_done is ignored in every state except WAIT. This includes a done pulse arriving in the START cycle.
- in_ready=0 in START, WAIT and RESP; input bytes presented then are not consumed.
- load_a and load_b are mutually exclusive and never both high.
- data_out=in_data in every state.

## Timing
- Reset values: all outputs 0, state IDLE, op_count 8'h00, err 0, timeout counter 0.
- Exception at reset: in_ready reads 1 in the first cycle after reset, because the state is IDLE.
- Load latency is zero: the load strobe rises in the handshake cycle, and the operand register captures the byte at that cycle's clock edge.
- Minimum sequence: A handshake (cycle 0), B handshake (cycle 1), alu_start (cycle 2), WAIT from cycle 3.
- res_valid rises in the cycle after alu_done is sampled.
- Back-to-back operation: res_ready in cycle N returns to IDLE, so an A byte is accepted in cycle N+1.
- Reset mid-operation: the state machine returns to IDLE on the next edge regardless of state; a pending result is discarded. The operand registers clear on the same edge.
- Simultaneous rst and in_valid: rst wins; no load strobe takes effect.

## Configuration
- ALU_TIMEOUT_EN defined:
  - The counter increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES-1 with no alu_done: err=1, op_count unchanged, go to RESP.
  - If alu_done arrives in the same cycle the timeout would fire, done wins: normal completion, no error.
  - The counter clears on entry to WAIT.
- ALU_TIMEOUT_EN undefined: no counter is synthesized, and err is tied to 0.

## Structure
- Package operand_ctrl_pkg holds:
  - the state enum ctrl_state_t (IDLE, GET_B, START, WAIT, RESP);
  - the constant OP_COUNT_W=8.
- Single flat module; no sub-module. The timeout counter is inline under the macro.

## Test plan
- Reset check: assert rst for 2 cycles, then release → all outputs 0, in_ready=1, op_count=0.
- Basic operation: bytes 8'h3C then 8'hA5, alu_done 4 cycles after start, res_ready=1:
  - load_a in cycle 0 with data_out=3C, load_b in cycle 1 with data_out=A5;
  - alu_start in cycle 2, res_valid in cycle 7, op_count=1.
- Backpressure: hold in_valid=1 through START, WAIT and RESP → no load strobes fire and in_ready=0 until RESP exits.
- Count wrap: op_count preloaded to 255 by running 255 operations, then one more → op_count=0.
- Mid-operation reset: rst asserted during WAIT, then alu_done → state IDLE, res_valid never rises, op_count unchanged.
- Timeout (ALU_TIMEOUT_EN defined): withhold alu_done → err=1 and res_valid=1 at WAIT cycle 16; the next A handshake clears err.
